// File: rtl/codec_init_pkg.sv
// Shared types and constants for the codec init sequencer.
package codec_init_pkg;

    // Sequencer states.
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT     = 3'd1,
        ST_GAP      = 3'd2,
        ST_READY    = 3'd3,
        ST_MAN_WAIT = 3'd4,
        ST_MAN_GAP  = 3'd5,
        ST_FAIL     = 3'd6
    } state_t;

    // Error code reported when the controller never signals completion.
    localparam logic [3:0] ERR_TIMEOUT = 4'hF;

    // Default six-entry table, entry 0 in the least significant 16 bits.
    // Each entry is {register[6:0], data[8:0]}.
    localparam logic [95:0] DEFAULT_INIT_TABLE = {
        7'h06, 9'h000,
        7'h09, 9'h001,
        7'h05, 9'h000,
        7'h04, 9'h018,
        7'h07, 9'h053,
        7'h06, 9'h010
    };

    // Index width for a table of n entries, never less than one bit.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/codec_init_rom.sv
// Combinational lookup of one {register, data} entry from the flat init table.
module codec_init_rom
    import codec_init_pkg::*;
#(
    parameter int N_INIT = 6,
    parameter int REG_W  = 7,
    parameter int DATA_W = 9,
    parameter int IDX_W  = 3,
    parameter logic [N_INIT*(REG_W+DATA_W)-1:0] INIT_TABLE = DEFAULT_INIT_TABLE
)(
    input  logic [IDX_W-1:0]  i_idx,
    output logic [REG_W-1:0]  o_register,
    output logic [DATA_W-1:0] o_data
);

    localparam int ENT_W = REG_W + DATA_W;

    logic [ENT_W-1:0] w_entry;

    // Select the indexed entry; indices past the table read as zero.
    always_comb begin
        w_entry = '0;
        for (int k = 0; k < N_INIT; k++) begin
            if (i_idx == IDX_W'(k)) begin
                w_entry = INIT_TABLE[k*ENT_W +: ENT_W];
            end
        end
    end

    assign o_register = w_entry[ENT_W-1:DATA_W];
    assign o_data     = w_entry[DATA_W-1:0];

endmodule

// File: rtl/codec_init_seq.sv
// Table-driven codec configuration sequencer with retry, watchdog and
// inter-write gap, followed by single manual writes via req/ack.
module codec_init_seq
    import codec_init_pkg::*;
#(
    parameter int N_INIT         = 6,
    parameter int REG_W          = 7,
    parameter int DATA_W         = 9,
    parameter logic [N_INIT*(REG_W+DATA_W)-1:0] INIT_TABLE = DEFAULT_INIT_TABLE,
    parameter int MAX_RETRY      = 2,
    parameter int GAP_CYCLES     = 16,
    parameter int TIMEOUT_CYCLES = 65535,
    localparam int IDX_W         = idx_width(N_INIT)
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              init_start,
    output logic              i2c_en,
    output logic [REG_W-1:0]  i2c_register,
    output logic [DATA_W-1:0] i2c_data,
    input  logic              i2c_done,
    input  logic [3:0]        i2c_error,
    output logic              init_done,
    output logic              init_fail,
    output logic [IDX_W-1:0]  fail_index,
    output logic [3:0]        last_error,
    output logic              busy,
    input  logic              man_req,
    input  logic [REG_W-1:0]  man_register,
    input  logic [DATA_W-1:0] man_data,
    output logic              man_ack,
    output logic              man_err
);

    // The index must be able to hold N_INIT ("past the last entry").
    localparam int CIDX_W  = IDX_W + 1;
    localparam int RTR_W   = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam int CNT_MAX = (TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    state_t              r_state, w_state_nxt;
    logic [CIDX_W-1:0]   r_idx, w_idx_nxt;
    logic [RTR_W-1:0]    r_retry, w_retry_nxt;
    logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
    logic                r_en, w_en_nxt;
    logic [REG_W-1:0]    r_reg, w_reg_nxt;
    logic [DATA_W-1:0]   r_data, w_data_nxt;
    logic                r_done, w_done_nxt;
    logic                r_fail, w_fail_nxt;
    logic [IDX_W-1:0]    r_fail_idx, w_fail_idx_nxt;
    logic [3:0]          r_last_err, w_last_err_nxt;
    logic                r_man_ack, w_man_ack_nxt;
    logic                r_man_err, w_man_err_nxt;

    logic                w_idle_like;
    logic [IDX_W-1:0]    w_rom_idx;
    logic [REG_W-1:0]    w_rom_reg;
    logic [DATA_W-1:0]   w_rom_data;
    logic                w_timeout;
    logic                w_gap_end;
    logic                w_resp;
    logic [3:0]          w_err;

    // States that wait for a command; the only table load from here is entry 0.
    assign w_idle_like = (r_state == ST_IDLE) || (r_state == ST_READY) || (r_state == ST_FAIL);
    assign w_rom_idx   = w_idle_like ? '0 : r_idx[IDX_W-1:0];

    codec_init_rom #(
        .N_INIT     (N_INIT),
        .REG_W      (REG_W),
        .DATA_W     (DATA_W),
        .IDX_W      (IDX_W),
        .INIT_TABLE (INIT_TABLE)
    ) u_rom (
        .i_idx      (w_rom_idx),
        .o_register (w_rom_reg),
        .o_data     (w_rom_data)
    );

    // One counter serves both the watchdog (WAIT states) and the gap (GAP states).
    assign w_timeout = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign w_gap_end = (r_cnt == CNT_W'(GAP_CYCLES - 1));
    assign w_resp    = i2c_done || w_timeout;
    assign w_err     = i2c_done ? i2c_error : ERR_TIMEOUT;

    // Next-state and next-register values for the whole sequencer.
    always_comb begin
        w_state_nxt    = r_state;
        w_idx_nxt      = r_idx;
        w_retry_nxt    = r_retry;
        w_cnt_nxt      = r_cnt;
        w_en_nxt       = r_en;
        w_reg_nxt      = r_reg;
        w_data_nxt     = r_data;
        w_done_nxt     = r_done;
        w_fail_nxt     = r_fail;
        w_fail_idx_nxt = r_fail_idx;
        w_last_err_nxt = r_last_err;
        w_man_ack_nxt  = 1'b0;
        w_man_err_nxt  = r_man_err;

        case (r_state)
            ST_IDLE, ST_READY, ST_FAIL: begin
                if (init_start) begin
                    w_done_nxt  = 1'b0;
                    w_fail_nxt  = 1'b0;
                    w_retry_nxt = '0;
                    w_idx_nxt   = '0;
                    w_reg_nxt   = w_rom_reg;
                    w_data_nxt  = w_rom_data;
                    w_en_nxt    = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_WAIT;
                end else if ((r_state == ST_READY) && man_req) begin
                    w_reg_nxt   = man_register;
                    w_data_nxt  = man_data;
                    w_en_nxt    = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_MAN_WAIT;
                end
            end

            ST_WAIT: begin
                w_cnt_nxt = r_cnt + CNT_W'(1);
                if (w_resp) begin
                    w_en_nxt  = 1'b0;
                    w_cnt_nxt = '0;
                    if (w_err == 4'h0) begin
                        w_retry_nxt = '0;
                        w_idx_nxt   = r_idx + CIDX_W'(1);
                        w_state_nxt = ST_GAP;
                    end else begin
                        w_last_err_nxt = w_err;
                        if (r_retry >= RTR_W'(MAX_RETRY)) begin
                            w_fail_idx_nxt = r_idx[IDX_W-1:0];
                            w_fail_nxt     = 1'b1;
                            w_state_nxt    = ST_FAIL;
                        end else begin
                            // Index unchanged, so GAP re-issues the same entry.
                            w_retry_nxt = r_retry + RTR_W'(1);
                            w_state_nxt = ST_GAP;
                        end
                    end
                end
            end

            ST_GAP: begin
                w_cnt_nxt = r_cnt + CNT_W'(1);
                if (w_gap_end) begin
                    w_cnt_nxt = '0;
                    if (r_idx >= CIDX_W'(N_INIT)) begin
                        w_done_nxt  = 1'b1;
                        w_state_nxt = ST_READY;
                    end else begin
                        w_reg_nxt   = w_rom_reg;
                        w_data_nxt  = w_rom_data;
                        w_en_nxt    = 1'b1;
                        w_state_nxt = ST_WAIT;
                    end
                end
            end

            ST_MAN_WAIT: begin
                w_cnt_nxt = r_cnt + CNT_W'(1);
                if (w_resp) begin
                    w_en_nxt      = 1'b0;
                    w_cnt_nxt     = '0;
                    w_man_ack_nxt = 1'b1;
                    w_man_err_nxt = (w_err != 4'h0);
                    if (w_err != 4'h0) begin
                        w_last_err_nxt = w_err;
                    end
                    w_state_nxt = ST_MAN_GAP;
                end
            end

            ST_MAN_GAP: begin
                w_cnt_nxt = r_cnt + CNT_W'(1);
                if (w_gap_end) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_READY;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
                w_en_nxt    = 1'b0;
            end
        endcase
    end

    // State and output registers; reset drops i2c_en at once to abort the controller.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_idx      <= '0;
            r_retry    <= '0;
            r_cnt      <= '0;
            r_en       <= 1'b0;
            r_reg      <= '0;
            r_data     <= '0;
            r_done     <= 1'b0;
            r_fail     <= 1'b0;
            r_fail_idx <= '0;
            r_last_err <= 4'h0;
            r_man_ack  <= 1'b0;
            r_man_err  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_idx      <= w_idx_nxt;
            r_retry    <= w_retry_nxt;
            r_cnt      <= w_cnt_nxt;
            r_en       <= w_en_nxt;
            r_reg      <= w_reg_nxt;
            r_data     <= w_data_nxt;
            r_done     <= w_done_nxt;
            r_fail     <= w_fail_nxt;
            r_fail_idx <= w_fail_idx_nxt;
            r_last_err <= w_last_err_nxt;
            r_man_ack  <= w_man_ack_nxt;
            r_man_err  <= w_man_err_nxt;
        end
    end

    assign i2c_en       = r_en;
    assign i2c_register = r_reg;
    assign i2c_data     = r_data;
    assign init_done    = r_done;
    assign init_fail    = r_fail;
    assign fail_index   = r_fail_idx;
    assign last_error   = r_last_err;
    assign busy         = !w_idle_like;
    assign man_ack      = r_man_ack;
    assign man_err      = r_man_err;

endmodule

// File: tb/tb_codec_init_seq.sv
// Scoreboard bench for codec_init_seq: a table-level reference model predicts
// every controller transaction and the final sequence outcome.
module tb_codec_init_seq;
    import codec_init_pkg::*;

    localparam int N    = 6;
    localparam int RW   = 7;
    localparam int DW   = 9;
    localparam int MAXR = 2;
    localparam int GAP  = 16;
    localparam int TO   = 100;
    localparam int IW   = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          init_start;
    logic          i2c_en;
    logic [RW-1:0] i2c_register;
    logic [DW-1:0] i2c_data;
    logic          i2c_done;
    logic [3:0]    i2c_error;
    logic          init_done;
    logic          init_fail;
    logic [IW-1:0] fail_index;
    logic [3:0]    last_error;
    logic          busy;
    logic          man_req;
    logic [RW-1:0] man_register;
    logic [DW-1:0] man_data;
    logic          man_ack;
    logic          man_err;

    int checks = 0;
    int errors = 0;

    codec_init_seq #(
        .N_INIT         (N),
        .REG_W          (RW),
        .DATA_W         (DW),
        .MAX_RETRY      (MAXR),
        .GAP_CYCLES     (GAP),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .init_start   (init_start),
        .i2c_en       (i2c_en),
        .i2c_register (i2c_register),
        .i2c_data     (i2c_data),
        .i2c_done     (i2c_done),
        .i2c_error    (i2c_error),
        .init_done    (init_done),
        .init_fail    (init_fail),
        .fail_index   (fail_index),
        .last_error   (last_error),
        .busy         (busy),
        .man_req      (man_req),
        .man_register (man_register),
        .man_data     (man_data),
        .man_ack      (man_ack),
        .man_err      (man_err)
    );

    always #5 clk = ~clk;

    // Expected table contents, written out independently of the package.
    logic [RW-1:0] tb_reg [N] = '{7'h06, 7'h07, 7'h04, 7'h05, 7'h09, 7'h06};
    logic [DW-1:0] tb_dat [N] = '{9'h010, 9'h053, 9'h018, 9'h000, 9'h001, 9'h000};

    // Controller behaviour per entry and attempt: 0 ok, 1..15 error code, -1 never done.
    int plan [N][MAXR+1];

    typedef struct {
        logic [RW-1:0] rg;
        logic [DW-1:0] dt;
        int            hi;
        int            gap;
        bit            is_man;
        bit            man_err;
    } txn_t;

    typedef struct {
        int         dly;
        logic [3:0] err;
        bit         hang;
    } rsp_t;

    txn_t exp_q [$];
    rsp_t rsp_q [$];

    logic [3:0]    m_last_err = 4'h0;
    logic [IW-1:0] m_fail_idx = '0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Controller model: answers each i2c_en rise from the response queue.
    initial begin
        bit   rs_prev;
        rsp_t r;
        rs_prev   = 1'b0;
        i2c_done  = 1'b0;
        i2c_error = 4'h0;
        forever begin
            @(negedge clk);
            if (rst && i2c_en && !rs_prev) begin
                if (rsp_q.size() == 0) begin
                    r.dly = 0; r.err = 4'h0; r.hang = 1'b1;
                end else begin
                    r = rsp_q.pop_front();
                end
                if (!r.hang) begin
                    repeat (r.dly) @(negedge clk);
                    i2c_done  = 1'b1;
                    i2c_error = r.err;
                    @(negedge clk);
                    i2c_done  = 1'b0;
                    i2c_error = 4'h0;
                end
                for (int k = 0; k < 3*TO && i2c_en; k++) @(negedge clk);
                rs_prev = 1'b0;
            end else begin
                rs_prev = i2c_en;
            end
        end
    end

    // Monitor: pops the scoreboard on each transaction and checks its shape.
    initial begin
        bit   m_prev, m_have_cur, m_have_fall, m_fell;
        int   m_hi, m_lo;
        txn_t m_cur;
        m_prev = 0; m_have_cur = 0; m_have_fall = 0; m_hi = 0; m_lo = 0;
        forever begin
            @(negedge clk);
            m_fell = 1'b0;
            if (!rst) begin
                m_prev = 0; m_have_cur = 0; m_have_fall = 0; m_hi = 0; m_lo = 0;
            end else begin
                if (i2c_en && !m_prev) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_txn", int'(i2c_register), -1);
                        m_have_cur = 0;
                    end else begin
                        m_cur = exp_q.pop_front();
                        m_have_cur = 1;
                        check("txn_register", int'(i2c_register), int'(m_cur.rg));
                        check("txn_data", int'(i2c_data), int'(m_cur.dt));
                        if (m_cur.gap > 0 && m_have_fall) check("gap_cycles", m_lo, m_cur.gap);
                        if (m_cur.is_man) check("man_after_done", int'(init_done), 1);
                    end
                    m_hi = 1;
                end else if (i2c_en) begin
                    m_hi++;
                end else if (m_prev) begin
                    m_fell = 1'b1;
                    if (m_have_cur) begin
                        check("en_high_cycles", m_hi, m_cur.hi);
                        if (m_cur.is_man) begin
                            check("man_ack_pulse", int'(man_ack), 1);
                            check("man_err", int'(man_err), int'(m_cur.man_err));
                        end
                    end
                    m_have_fall = 1;
                    m_lo = 1;
                end else begin
                    m_lo++;
                end
                if (man_ack && !(m_fell && m_have_cur && m_cur.is_man))
                    check("spurious_man_ack", int'(man_ack), 0);
                if (m_fell) m_have_cur = 0;
                m_prev = i2c_en;
            end
        end
    end

    // Reference model: walk the table by its rules and queue what should happen.
    task automatic build_expect(output bit ok);
        bit   first;
        int   e;
        txn_t t;
        rsp_t r;
        ok    = 1'b1;
        first = 1'b1;
        for (int i = 0; i < N; i++) begin
            for (int a = 0; a <= MAXR; a++) begin
                e      = plan[i][a];
                r.hang = (e < 0);
                r.err  = r.hang ? 4'h0 : 4'(e);
                r.dly  = int'($urandom_range(1, 12));
                t.rg   = tb_reg[i];
                t.dt   = tb_dat[i];
                t.gap  = first ? 0 : GAP;
                t.hi   = r.hang ? TO : r.dly + 1;
                t.is_man  = 1'b0;
                t.man_err = 1'b0;
                first  = 1'b0;
                exp_q.push_back(t);
                rsp_q.push_back(r);
                if (e == 0) break;
                m_last_err = (e < 0) ? 4'hF : 4'(e);
                if (a == MAXR) begin
                    m_fail_idx = IW'(i);
                    ok = 1'b0;
                    return;
                end
            end
        end
    endtask

    task automatic queue_man(input logic [RW-1:0] mr, input logic [DW-1:0] md,
                             input int e, input int gap_exp);
        txn_t t;
        rsp_t r;
        r.hang    = (e < 0);
        r.err     = r.hang ? 4'h0 : 4'(e);
        r.dly     = int'($urandom_range(1, 12));
        t.rg      = mr;
        t.dt      = md;
        t.gap     = gap_exp;
        t.hi      = r.hang ? TO : r.dly + 1;
        t.is_man  = 1'b1;
        t.man_err = (e != 0);
        if (e != 0) m_last_err = (e < 0) ? 4'hF : 4'(e);
        exp_q.push_back(t);
        rsp_q.push_back(r);
    endtask

    task automatic wait_ack();
        for (int k = 0; k < 400 && !man_ack; k++) @(negedge clk);
        check("man_ack_seen", int'(man_ack), 1);
        man_req = 1'b0;
        repeat (GAP + 4) @(negedge clk);
    endtask

    task automatic final_checks(input bit ok);
        check("init_done", int'(init_done), int'(ok));
        check("init_fail", int'(init_fail), int'(!ok));
        check("fail_index", int'(fail_index), int'(m_fail_idx));
        check("last_error", int'(last_error), int'(m_last_err));
        check("busy_idle", int'(busy), 0);
        check("txns_pending", exp_q.size(), 0);
    endtask

    task automatic run_init(input bit with_man, input logic [RW-1:0] mr,
                            input logic [DW-1:0] md, output bit ok);
        build_expect(ok);
        if (with_man) queue_man(mr, md, 0, GAP + 1);
        @(negedge clk);
        init_start = 1'b1;
        if (with_man) begin
            man_req = 1'b1; man_register = mr; man_data = md;
        end
        @(negedge clk);
        init_start = 1'b0;
        check("start_latency_en", int'(i2c_en), 1);
        check("busy_running", int'(busy), 1);
        for (int k = 0; k < 5000 && !(init_done || init_fail); k++) @(negedge clk);
        check("seq_finished", int'(init_done || init_fail), 1);
        if (with_man) wait_ack();
        repeat (GAP + 4) @(negedge clk);
        final_checks(ok);
    endtask

    task automatic run_man(input logic [RW-1:0] mr, input logic [DW-1:0] md, input int e);
        queue_man(mr, md, e, 0);
        @(negedge clk);
        man_req = 1'b1; man_register = mr; man_data = md;
        wait_ack();
        check("man_last_error", int'(last_error), int'(m_last_err));
        check("man_busy_idle", int'(busy), 0);
        check("man_keeps_done", int'(init_done), 1);
        check("man_txns_pending", exp_q.size(), 0);
    endtask

    task automatic clear_plan();
        for (int i = 0; i < N; i++)
            for (int a = 0; a <= MAXR; a++) plan[i][a] = 0;
    endtask

    function automatic int rand_code(input int ok_pct);
        int x;
        x = int'($urandom_range(0, 99));
        if (x < ok_pct) return 0;
        if (x < 96) return int'($urandom_range(1, 15));
        return -1;
    endfunction

    initial begin
        bit ok;
        rst = 1'b0; init_start = 1'b0; man_req = 1'b0;
        man_register = '0; man_data = '0;

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_i2c_en", int'(i2c_en), 0);
        check("rst_i2c_register", int'(i2c_register), 0);
        check("rst_i2c_data", int'(i2c_data), 0);
        check("rst_init_done", int'(init_done), 0);
        check("rst_init_fail", int'(init_fail), 0);
        check("rst_fail_index", int'(fail_index), 0);
        check("rst_last_error", int'(last_error), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_man_ack", int'(man_ack), 0);
        check("rst_man_err", int'(man_err), 0);
        #2 rst = 1'b1;

        // Clean default table.
        clear_plan();
        run_init(1'b0, '0, '0, ok);

        // Entry 2 fails twice with code 2, then succeeds.
        clear_plan();
        plan[2][0] = 2; plan[2][1] = 2;
        run_init(1'b0, '0, '0, ok);

        // Entry 3 always fails with code 1.
        clear_plan();
        for (int a = 0; a <= MAXR; a++) plan[3][a] = 1;
        run_init(1'b0, '0, '0, ok);

        // Controller never completes: watchdog, retries, then FAIL on entry 0.
        clear_plan();
        for (int a = 0; a <= MAXR; a++) plan[0][a] = -1;
        run_init(1'b0, '0, '0, ok);

        // Manual request held through the whole init, serviced afterwards.
        clear_plan();
        run_init(1'b1, 7'h02, 9'h17F, ok);

        // A few manual writes with assorted outcomes.
        run_man(7'h11, 9'h0AA, 0);
        run_man(7'h12, 9'h155, 3);
        run_man(7'h13, 9'h001, -1);

        // Reset in the middle of entry 4's transaction, then a full restart.
        clear_plan();
        for (int a = 0; a <= MAXR; a++) plan[4][a] = -1;
        build_expect(ok);
        @(negedge clk); init_start = 1'b1;
        @(negedge clk); init_start = 1'b0;
        for (int k = 0; k < 3000 && !(i2c_en && exp_q.size() == 2); k++) @(negedge clk);
        check("reach_entry4", int'(i2c_en && exp_q.size() == 2), 1);
        repeat (10) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("rst_async_en", int'(i2c_en), 0);
        check("rst_async_busy", int'(busy), 0);
        check("rst_async_last_error", int'(last_error), 0);
        check("rst_async_register", int'(i2c_register), 0);
        exp_q.delete();
        rsp_q.delete();
        m_last_err = 4'h0;
        m_fail_idx = '0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        clear_plan();
        run_init(1'b0, '0, '0, ok);

        // Randomised tables of controller behaviour plus manual traffic.
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < N; i++)
                for (int a = 0; a <= MAXR; a++) plan[i][a] = rand_code(70);
            run_init(1'b0, '0, '0, ok);
            if (ok) begin
                repeat ($urandom_range(0, 2))
                    run_man(RW'($urandom), DW'($urandom), rand_code(75));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench time limit exceeded");
    end

endmodule

// File: doc/codec_init_seq.md
# codec_init_seq

Parametrised codec configuration sequencer: after a start pulse it walks a table of N_INIT register/data words through the external `i2c_controller`, with per-entry retry, a watchdog timeout and a programmable inter-write gap. It then serves single manual writes through a req/ack handshake. It sits between top-level control and `i2c_controller`, replacing the fixed six-write init with a table-driven, fault-reporting one.

## Interface

- N_INIT, 6: number of table entries (≥1).
- REG_W, 7: register address width.
- DATA_W, 9: data word width.
- INIT_TABLE, {06/010, 07/053, 04/018, 05/000, 09/001, 06/000}: flat vector of N_INIT×(REG_W+DATA_W) bits.
  - Entry i occupies bits [(i+1)W−1 : iW], where W = REG_W+DATA_W.
  - Register is in the upper REG_W bits, data in the lower DATA_W bits.
- MAX_RETRY, 2: re-issues allowed per entry after the first attempt fails.
- GAP_CYCLES, 16: cycles `i2c_en` is held low between transactions (≥1).
- TIMEOUT_CYCLES, 65535: maximum cycles in a wait state before a forced error.
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- init_start  in  1  pulse that starts or restarts the table sequence.
- i2c_en  out  1  level enable to `i2c_controller`; held high for the whole transaction.
- i2c_register  out  REG_W  register address to the controller.
- i2c_data  out  DATA_W  data word to the controller.
- i2c_done  in  1  controller completion.
- i2c_error  in  4  controller error code, sampled with `i2c_done`; nonzero means failure.
- init_done  out  1  sequence completed successfully (level).
- init_fail  out  1  sequence aborted (level).
- fail_index  out  IDX_W  entry that exhausted its retries; IDX_W = max(1, clog2(N_INIT)).
- last_error  out  4  most recent nonzero error code; 4'hF means timeout.
- busy  out  1  high in every state except IDLE, READY and FAIL.
- man_req  in  1  level request for a manual write.
- man_register  in  REG_W  manual write register address.
- man_data  in  DATA_W  manual write data.
- man_ack  out  1  one-cycle pulse when the manual write completes.
- man_err  out  1  manual write failed; valid with `man_ack`.

## Operation

- Reset values:
  - All outputs are 0.
  - State is IDLE; index and retry counters are 0.
- States: IDLE, WAIT, GAP, READY, MAN_WAIT, MAN_GAP, FAIL.
- IDLE / FAIL / READY receiving `init_start`:
  - Clear `init_done`, `init_fail` and the retry count; set index to 0.
  - Load entry 0 into `i2c_register`/`i2c_data` and set `i2c_en`=1, all on the same edge.
  - Go to WAIT.
- WAIT:
  - On `i2c_done`=1, or when the timeout counter reaches TIMEOUT_CYCLES (error treated as 4'hF), clear `i2c_en`.
  - Success (error 0): clear the retry count, advance the index, go to GAP.
  - Error with retry < MAX_RETRY: latch `last_error`, increment retry, go to GAP; the same entry is re-issued.
  - Error with retry = MAX_RETRY: latch `last_error`, set `fail_index` to the index, set `init_fail`, go to FAIL.
- GAP:
  - Count GAP_CYCLES with `i2c_en` low.
  - If the index has advanced past N_INIT−1: set `init_done`, go to READY.
  - Otherwise load the current entry, set `i2c_en`, go to WAIT.
- READY:
  - `init_start` has priority over `man_req`.
  - `man_req`=1: latch `man_register`/`man_data`, set `i2c_en`, go to MAN_WAIT.
- MAN_WAIT:
  - Completes on done or timeout; there is no retry.
  - Clear `i2c_en`, pulse `man_ack`, set `man_err` = (error≠0); latch `last_error` if nonzero; go to MAN_GAP.
- MAN_GAP: GAP_CYCLES with `i2c_en` low, then READY.
- `man_req` outside READY is neither acked nor dropped; it is serviced on entry to READY if it is still high.
- FAIL: held until `init_start` or reset.
- `init_start` in WAIT, GAP or the manual states is ignored.
- Reset mid-transaction drops `i2c_en` immediately, which aborts the controller.

## Timing

- Latency from `init_start` to `i2c_en` rising: 1 edge.
- `i2c_done` to `i2c_en` low: 1 edge. This equals the `man_ack` pulse edge in manual mode.
- Between transactions `i2c_en` is low for exactly GAP_CYCLES cycles.
- Fault-free sequence: `init_done` rises GAP_CYCLES cycles after the last `i2c_done`.
- The timeout counter restarts on every entry to WAIT or MAN_WAIT.
- `man_req` must be dropped on `man_ack`; if it is still high in READY, a second write is issued.

## Structure

- Package `codec_init_pkg` holds:
  - the state enum;
  - ERR_TIMEOUT = 4'hF;
  - the default INIT_TABLE constant.
- Sub-module `codec_init_rom` performs the combinational index→{register, data} slice of INIT_TABLE.
- Gap and timeout share one counter.

## Test plan

- Default table, controller model always clean with done 5 cycles after enable → six transactions with register order 06, 07, 04, 05, 09, 06 and data 010, 053, 018, 000, 001, 000; `init_done`=1; `busy`=0.
- Entry 2 returns error 4'h2 twice, then succeeds → entry 2 is issued 3 times, `init_done`=1, `last_error`=2.
- Entry 3 always returns error 4'h1 → 3 attempts, `init_fail`=1, `fail_index`=3, no entry 4 issued.
- Controller never asserts done, with TIMEOUT_CYCLES=100 → `i2c_en` drops at 100 cycles, `last_error`=F, retries follow, then FAIL.
- `man_req` held during init with register 0x02, data 0x17F → serviced only after `init_done`; one `man_ack` with `man_err`=0.
- Reset asserted mid-WAIT of entry 4 → `i2c_en`=0 asynchronously; a new `init_start` restarts from entry 0.
